// File: rtl/dir_coherence_pkg.sv
// Shared coherence definitions for the directory state machine.
//   coh_state_t : 2-bit line state
//   INVALID / SHARED / MODIFIED : state encodings (2'b01 is reserved)
//   OP_READ / OP_WRITE          : processor opcode encodings
//   normState()                 : folds the reserved encoding onto INVALID
package dir_coherence_pkg;

   typedef logic [1:0] coh_state_t;

   localparam coh_state_t INVALID  = 2'b00;
   localparam coh_state_t SHARED   = 2'b10;
   localparam coh_state_t MODIFIED = 2'b11;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // 2'b01 never leaves this block as a decoded state; it behaves as INVALID.
   function automatic coh_state_t normState(input coh_state_t s);
      return (s == SHARED || s == MODIFIED) ? s : INVALID;
   endfunction

endpackage

// File: rtl/directory_state_machine_if.sv
// Processor-side and snooped-bus signal bundle for directory_state_machine.
//   master : requester side (drives requests/snoops, receives results)
//   slave  : state machine side
//   cpu_*  : request strobe, opcode, hit, line state; miss/invalidate/write_back
//            messages and next line state
//   bus_*  : snoop strobe, incoming messages, line state; next line state and
//            write_back
interface directory_state_machine_if;
   import dir_coherence_pkg::*;

   logic       cpu_valid;
   logic       cpu_op;
   logic       cpu_hit;
   coh_state_t cpu_state;
   logic       cpu_read_miss;
   logic       cpu_write_miss;
   logic       cpu_invalidate;
   logic       cpu_write_back;
   coh_state_t cpu_new_state;

   logic       bus_valid;
   logic       bus_read_miss;
   logic       bus_write_miss;
   logic       bus_invalidate;
   coh_state_t bus_state;
   coh_state_t bus_new_state;
   logic       bus_write_back;

   modport master (
      output cpu_valid, cpu_op, cpu_hit, cpu_state,
      output bus_valid, bus_read_miss, bus_write_miss, bus_invalidate, bus_state,
      input  cpu_read_miss, cpu_write_miss, cpu_invalidate, cpu_write_back,
      input  cpu_new_state, bus_new_state, bus_write_back
   );

   modport slave (
      input  cpu_valid, cpu_op, cpu_hit, cpu_state,
      input  bus_valid, bus_read_miss, bus_write_miss, bus_invalidate, bus_state,
      output cpu_read_miss, cpu_write_miss, cpu_invalidate, cpu_write_back,
      output cpu_new_state, bus_new_state, bus_write_back
   );

endinterface

// File: rtl/directory_state_machine_bus_snoop.sv
// Combinational snoop response: next state and write_back for the line
// addressed by an incoming interconnect message.
//   valid, readMiss, writeMiss, invalidate : snooped message
//   state                                  : current line state
//   newState, writeBack                    : response (unregistered)
module dsm_bus_snoop
   import dir_coherence_pkg::*;
(
   input  logic       valid,
   input  logic       readMiss,
   input  logic       writeMiss,
   input  logic       invalidate,
   input  coh_state_t state,
   output coh_state_t newState,
   output logic       writeBack
);

   logic anyMsg;
   // write_miss and invalidate both take ownership away; either outranks read_miss.
   logic kill;

   assign anyMsg = valid & (readMiss | writeMiss | invalidate);
   assign kill   = writeMiss | invalidate;

   always_comb begin
      newState  = state;
      writeBack = 1'b0;
      if (anyMsg) begin
         case (normState(state))
            SHARED: begin
               newState = kill ? INVALID : SHARED;
            end
            MODIFIED: begin
               newState  = kill ? INVALID : SHARED;
               writeBack = 1'b1;
            end
            default: begin
               newState = INVALID;
            end
         endcase
      end
   end

endmodule

// File: rtl/directory_state_machine.sv
// MSI-style coherence state machine for one cache port. Each cycle the
// processor request and the snooped bus message are resolved independently;
// every result is registered (one cycle of latency).
//   clk, rst_n : clock, asynchronous active-low reset
//   dir        : request/snoop bundle (slave side)
module directory_state_machine
   import dir_coherence_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   directory_state_machine_if.slave    dir
);

   logic       cRm, cWm, cInv, cWb;
   coh_state_t cNs;
   coh_state_t bNs;
   logic       bWb;

   // Processor side. Only one interconnect message is ever chosen per request.
   always_comb begin
      cRm  = 1'b0;
      cWm  = 1'b0;
      cInv = 1'b0;
      cWb  = 1'b0;
      cNs  = dir.cpu_state;
      if (dir.cpu_valid) begin
         case (normState(dir.cpu_state))
            SHARED: begin
               if (dir.cpu_op == OP_WRITE) begin
                  cNs  = MODIFIED;
                  cInv = dir.cpu_hit;
                  cWm  = ~dir.cpu_hit;
               end else begin
                  cNs = SHARED;
                  cRm = ~dir.cpu_hit;
               end
            end
            MODIFIED: begin
               if (dir.cpu_hit) begin
                  cNs = MODIFIED;
               end else begin
                  // Replacing a dirty line: evict it alongside the miss.
                  cWb = 1'b1;
                  if (dir.cpu_op == OP_WRITE) begin
                     cWm = 1'b1;
                     cNs = MODIFIED;
                  end else begin
                     cRm = 1'b1;
                     cNs = SHARED;
                  end
               end
            end
            default: begin
               // INVALID (and reserved): always a miss, hit is meaningless.
               if (dir.cpu_op == OP_WRITE) begin
                  cWm = 1'b1;
                  cNs = MODIFIED;
               end else begin
                  cRm = 1'b1;
                  cNs = SHARED;
               end
            end
         endcase
      end
   end

   dsm_bus_snoop uSnoop (
      .valid      (dir.bus_valid),
      .readMiss   (dir.bus_read_miss),
      .writeMiss  (dir.bus_write_miss),
      .invalidate (dir.bus_invalidate),
      .state      (dir.bus_state),
      .newState   (bNs),
      .writeBack  (bWb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir.cpu_read_miss  <= 1'b0;
         dir.cpu_write_miss <= 1'b0;
         dir.cpu_invalidate <= 1'b0;
         dir.cpu_write_back <= 1'b0;
         dir.cpu_new_state  <= INVALID;
         dir.bus_new_state  <= INVALID;
         dir.bus_write_back <= 1'b0;
      end else begin
         dir.cpu_read_miss  <= cRm;
         dir.cpu_write_miss <= cWm;
         dir.cpu_invalidate <= cInv;
         dir.cpu_write_back <= cWb;
         dir.cpu_new_state  <= cNs;
         dir.bus_new_state  <= bNs;
         dir.bus_write_back <= bWb;
      end
   end

endmodule

// File: tb/tb_directory_state_machine.sv
module tb_directory_state_machine;
   import dir_coherence_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   directory_state_machine_if dif();

   directory_state_machine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dir   (dif)
   );

   // Expected output packing: {crm, cwm, cinv, cwb, cns[1:0], bns[1:0], bwb}
   typedef struct {
      string      name;
      logic       cv, op, hit;
      logic [1:0] cs;
      logic       bv, brm, bwm, binv;
      logic [1:0] bs;
      logic [8:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [8:0] exp;
   } sb_t;

   sb_t  sbq[$];
   int   nCmp = 0;
   int   nBad = 0;
   vec_t vecs[$];

   function automatic logic [8:0] actual();
      return {dif.cpu_read_miss, dif.cpu_write_miss, dif.cpu_invalidate,
              dif.cpu_write_back, dif.cpu_new_state, dif.bus_new_state,
              dif.bus_write_back};
   endfunction

   task automatic check(input string name, input logic [8:0] exp);
      logic [8:0] act;
      act = actual();
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %b want %b (crm cwm cinv cwb cns bns bwb)",
                  name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      dif.cpu_valid      = v.cv;
      dif.cpu_op         = v.op;
      dif.cpu_hit        = v.hit;
      dif.cpu_state      = v.cs;
      dif.bus_valid      = v.bv;
      dif.bus_read_miss  = v.brm;
      dif.bus_write_miss = v.bwm;
      dif.bus_invalidate = v.binv;
      dif.bus_state      = v.bs;
   endtask

   task automatic issue(input vec_t v);
      sb_t e;
      @(negedge clk);
      drive(v);
      e.name = v.name;
      e.exp  = v.exp;
      sbq.push_back(e);
   endtask

   task automatic addVec(input string n, input logic cv, input logic op,
                         input logic hit, input logic [1:0] cs, input logic bv,
                         input logic brm, input logic bwm, input logic binv,
                         input logic [1:0] bs, input logic [8:0] exp);
      vec_t v;
      v.name = n; v.cv = cv; v.op = op; v.hit = hit; v.cs = cs;
      v.bv = bv; v.brm = brm; v.bwm = bwm; v.binv = binv; v.bs = bs;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   // Monitor: outputs are valid every cycle; consume one expectation per edge.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.name, e.exp);
         end
      end
   end

   initial begin
      vec_t idle;
      int   budget;
      //        name          cv op hit cs     bv rm wm inv bs        crm cwm cinv cwb cns   bns   bwb
      addVec("s_wr_hit",      1, 1, 1, 2'b10, 0, 0, 0, 0, 2'b00, 9'b0_0_1_0_11_00_0);
      addVec("m_rd_miss",     1, 0, 0, 2'b11, 1, 1, 0, 0, 2'b11, 9'b1_0_0_1_10_10_1);
      addVec("i_rd",          1, 0, 1, 2'b00, 1, 1, 0, 0, 2'b10, 9'b1_0_0_0_10_10_0);
      addVec("i_wr_prio",     1, 1, 0, 2'b00, 1, 1, 1, 0, 2'b10, 9'b0_1_0_0_11_00_0);
      addVec("rsv_wr",        1, 1, 1, 2'b01, 1, 0, 0, 1, 2'b11, 9'b0_1_0_0_11_00_1);
      addVec("s_rd_hit",      1, 0, 1, 2'b10, 1, 0, 1, 0, 2'b11, 9'b0_0_0_0_10_00_1);
      addVec("s_rd_miss",     1, 0, 0, 2'b10, 1, 1, 0, 0, 2'b00, 9'b1_0_0_0_10_00_0);
      addVec("s_wr_miss",     1, 1, 0, 2'b10, 1, 0, 0, 1, 2'b10, 9'b0_1_0_0_11_00_0);
      addVec("m_wr_hit",      1, 1, 1, 2'b11, 1, 0, 0, 0, 2'b11, 9'b0_0_0_0_11_11_0);
      addVec("m_rd_hit",      1, 0, 1, 2'b11, 0, 1, 0, 0, 2'b10, 9'b0_0_0_0_11_10_0);
      addVec("m_wr_miss",     1, 1, 0, 2'b11, 1, 1, 0, 1, 2'b11, 9'b0_1_0_1_11_00_1);
      addVec("idle",          0, 1, 0, 2'b10, 0, 0, 0, 0, 2'b11, 9'b0_0_0_0_10_11_0);
      addVec("rsv_rd",        1, 0, 0, 2'b01, 1, 1, 0, 0, 2'b01, 9'b1_0_0_0_10_00_0);
      addVec("idle_rsv",      0, 0, 0, 2'b01, 0, 0, 0, 0, 2'b01, 9'b0_0_0_0_01_01_0);

      idle.name = "idle"; idle.cv = 0; idle.op = 0; idle.hit = 0; idle.cs = 2'b00;
      idle.bv = 0; idle.brm = 0; idle.bwm = 0; idle.binv = 0; idle.bs = 2'b00;
      idle.exp = '0;
      drive(idle);

      #2;
      check("reset_init", 9'b0);
      repeat (2) @(posedge clk);

      // First edge after release must already give normal results.
      @(negedge clk);
      rst_n = 1'b1;
      issue(vecs[0]);
      issue(vecs[1]);

      // Outputs are nonzero now; reset must clear them without a clock edge.
      @(negedge clk);
      drive(idle);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_async", 9'b0);
      @(posedge clk);
      #1;
      check("reset_hold", 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(vecs[1]);

      for (int i = 2; i < vecs.size(); i++) issue(vecs[i]);

      @(negedge clk);
      drive(idle);
      budget = 10;
      while (sbq.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (sbq.size() > 0) begin
         nCmp++;
         nBad++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/directory_state_machine.md
DIRECTORY_STATE_MACHINE -- requirements
Module: directory_state_machine

Interface
REQ-001 Parameters: none; state encoding and opcode constants come from the shared package.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_valid  in  1  processor-side request strobe for this cycle.
REQ-005 cpu_op  in  1  0 = read, 1 = write.
REQ-006 cpu_hit  in  1  tag match for the addressed line.
REQ-007 cpu_state  in  2  current coherence state of the addressed line.
REQ-008 cpu_read_miss / cpu_write_miss / cpu_invalidate  out  1 each  message placed on interconnect.
REQ-009 cpu_write_back  out  1  evicted Modified line must be written back.
REQ-010 cpu_new_state  out  2  next state for the addressed line.
REQ-011 bus_valid  in  1  snooped-message strobe for this cycle.
REQ-012 bus_read_miss / bus_write_miss / bus_invalidate  in  1 each  incoming interconnect message.
REQ-013 bus_state  in  2  current state of the line addressed by the bus message.
REQ-014 bus_new_state  out  2  next state for the snooped line.
REQ-015 bus_write_back  out  1  owner must supply or write back data.

Function
REQ-016 States SHALL be encoded as 2'b00 INVALID, 2'b10 SHARED, 2'b11 MODIFIED; 2'b01 is reserved and SHALL be treated as INVALID.
REQ-017 All outputs SHALL be registered: values are computed from the inputs sampled at a rising edge and appear after that edge (latency 1), holding until the next edge.
REQ-018 When cpu_valid=0, the CPU message and write_back outputs SHALL be 0 and cpu_new_state SHALL equal the sampled cpu_state.
REQ-019 When cpu_valid=1, the CPU-side outputs SHALL be as follows:
- INVALID: read -> read_miss, SHARED; write -> write_miss, MODIFIED (hit ignored).
- SHARED: read hit -> no message, SHARED; read miss -> read_miss, SHARED; write hit -> invalidate, MODIFIED; write miss -> write_miss, MODIFIED.
- MODIFIED: hit -> no message, MODIFIED; read miss -> write_back and read_miss, SHARED; write miss -> write_back and write_miss, MODIFIED.
REQ-020 At most one of cpu_read_miss, cpu_write_miss and cpu_invalidate SHALL be asserted in any cycle.
REQ-021 When bus_valid=0, or no bus message bit is set, bus_write_back SHALL be 0 and bus_new_state SHALL equal bus_state.
REQ-022 Bus message priority SHALL be write_miss > invalidate > read_miss when several are set.
REQ-023 The bus-side outputs SHALL be as follows:
- INVALID: any message -> INVALID, no write_back.
- SHARED: read_miss -> SHARED; write_miss or invalidate -> INVALID; write_back=0.
- MODIFIED: read_miss -> SHARED with write_back=1; write_miss or invalidate -> INVALID with write_back=1.
REQ-024 The CPU side and the bus side SHALL evaluate independently in the same cycle; neither side blocks the other.

Reset
REQ-025 While rst_n=0, all message and write_back outputs SHALL be 0 and both new_state outputs SHALL be 2'b00, regardless of clk.
REQ-026 The first edge after rst_n deasserts SHALL produce normal REQ-017..REQ-023 results; no warm-up cycle is required.

Structure
REQ-027 The shared package dir_coherence_pkg SHALL hold the 2-bit state typedef, the INVALID/SHARED/MODIFIED constants and the READ/WRITE opcode constants.
REQ-028 The bus-side logic SHALL be one sub-module, dsm_bus_snoop (combinational next-state and write_back); the top SHALL hold the CPU logic and all output registers.

Verification
REQ-029 Reset: rst_n=0 mid-operation with outputs nonzero -> all outputs 0 immediately, new states 2'b00.
REQ-030 CPU write hit on SHARED (op=1, hit=1, state=10, valid=1) -> next cycle cpu_invalidate=1, cpu_new_state=11, other outputs 0.
REQ-031 CPU read miss on MODIFIED (op=0, hit=0, state=11) -> cpu_write_back=1, cpu_read_miss=1, cpu_new_state=10.
REQ-032 Bus read_miss on MODIFIED (bus_state=11) -> bus_new_state=10, bus_write_back=1; same message on SHARED -> 10, write_back 0.
REQ-033 Bus write_miss plus read_miss together on SHARED -> bus_new_state=00 (priority); reserved state 01 with a CPU write -> cpu_write_miss=1, cpu_new_state=11.
REQ-034 cpu_valid=0 and bus_valid=0 with cpu_state=10 and bus_state=11 -> no messages, cpu_new_state=10, bus_new_state=11.
